// File: rtl/pipe_idu.sv
// RV32I instruction-decode stage: one IF->ID register, immediate/flag decode,
// regfile read, load-use stall detection and a saturating stall counter.
module pipe_idu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        if_valid_i,
    input  logic [63:0] ifToId_i,
    output logic        id_ready_o,
    output logic [4:0]  rf_raddr1_o,
    output logic [4:0]  rf_raddr2_o,
    input  logic [31:0] rf_rdata1_i,
    input  logic [31:0] rf_rdata2_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_load_i,
    input  logic [4:0]  ex_rd_i,
    output logic        id_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] imm_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [4:0]  rd_o,
    output logic [3:0]  alu_op_o,
    output logic        wen_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        is_branch_o,
    output logic        is_jal_o,
    output logic        is_jalr_o,
    output logic        illegal_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [15:0] cnt_q;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic op_lui, op_auipc, op_jal, op_jalr, op_branch;
    logic op_load, op_store, op_imm, op_reg;
    logic uses_rs1, uses_rs2, stall, load;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm_d;
    logic [3:0]  alu_d;
    logic        wr_d;
    logic        illegal_d;

    function automatic logic [3:0] alu_fn(input logic [2:0] fn, input logic alt);
        logic [3:0] r;
        r = ALU_ADD;
        case (fn)
            3'b000: r = alt ? ALU_SUB : ALU_ADD;
            3'b001: r = ALU_SLL;
            3'b010: r = ALU_SLT;
            3'b011: r = ALU_SLTU;
            3'b100: r = ALU_XOR;
            3'b101: r = alt ? ALU_SRA : ALU_SRL;
            3'b110: r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    assign opc = inst_q[6:0];
    assign f3  = inst_q[14:12];
    assign rs1 = inst_q[19:15];
    assign rs2 = inst_q[24:20];
    assign rd  = inst_q[11:7];

    assign op_lui    = opc == 7'b0110111;
    assign op_auipc  = opc == 7'b0010111;
    assign op_jal    = opc == 7'b1101111;
    assign op_jalr   = opc == 7'b1100111;
    assign op_branch = opc == 7'b1100011;
    assign op_load   = opc == 7'b0000011;
    assign op_store  = opc == 7'b0100011;
    assign op_imm    = opc == 7'b0010011;
    assign op_reg    = opc == 7'b0110011;

    assign uses_rs1 = op_reg | op_imm | op_store | op_branch | op_jalr | op_load;
    assign uses_rs2 = op_reg | op_store | op_branch;

    assign stall = valid_q & ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0)
                 & ((uses_rs1 & (ex_rd_i == rs1)) | (uses_rs2 & (ex_rd_i == rs2)));

    assign id_ready_o = !flush_i & (!valid_q | (ex_ready_i & !stall));
    assign id_valid_o = valid_q & !stall & !flush_i;
    assign load       = if_valid_i & id_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= ifToId_i[63:32];
            inst_q  <= ifToId_i[31:0];
        end else if (id_valid_o & ex_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else if (stall && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7],
                    inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_u = {inst_q[31:12], 12'd0};
    assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12],
                    inst_q[20], inst_q[30:21], 1'b0};

    always_comb begin
        imm_d     = 32'd0;
        alu_d     = ALU_ADD;
        wr_d      = 1'b0;
        illegal_d = 1'b0;
        unique case (1'b1)
            op_lui:    begin imm_d = imm_u; alu_d = ALU_LUI; wr_d = 1'b1; end
            op_auipc:  begin imm_d = imm_u; wr_d = 1'b1; end
            op_jal:    begin imm_d = imm_j; wr_d = 1'b1; end
            op_jalr:   begin imm_d = imm_i; wr_d = 1'b1; end
            op_branch: begin imm_d = imm_b; alu_d = ALU_SUB; end
            op_load:   begin imm_d = imm_i; wr_d = 1'b1; end
            op_store:  begin imm_d = imm_s; end
            // only shifts read funct7 on OP-IMM; addi has no subtract form
            op_imm: begin
                imm_d = imm_i;
                alu_d = alu_fn(f3, inst_q[30] & (f3 == 3'b101));
                wr_d  = 1'b1;
            end
            op_reg:    begin alu_d = alu_fn(f3, inst_q[30]); wr_d = 1'b1; end
            default:   illegal_d = 1'b1;
        endcase
    end

    assign rf_raddr1_o = rs1;
    assign rf_raddr2_o = rs2;
    assign rs1_data_o  = (rs1 == 5'd0) ? 32'd0 : rf_rdata1_i;
    assign rs2_data_o  = (rs2 == 5'd0) ? 32'd0 : rf_rdata2_i;
    assign pc_o        = pc_q;

    assign imm_o       = valid_q ? imm_d : 32'd0;
    assign alu_op_o    = valid_q ? alu_d : ALU_ADD;
    assign rd_o        = valid_q ? rd : 5'd0;
    assign wen_o       = valid_q & wr_d & (rd != 5'd0);
    assign is_load_o   = valid_q & op_load;
    assign is_store_o  = valid_q & op_store;
    assign is_branch_o = valid_q & op_branch;
    assign is_jal_o    = valid_q & op_jal;
    assign is_jalr_o   = valid_q & op_jalr;
    assign illegal_o   = valid_q & illegal_d;
    assign stall_cnt_o = cnt_q;

endmodule

// File: doc/pipe_idu.md
PIPE_IDU -- requirements
Module: pipe_idu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC value held in the stage register after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction value held after reset or flush (addi x0,x0,0).
REQ-003 SHALL have ports clk_i (in, 1, clock) and rst_i (in, 1); reset rst_i is asynchronous, active-high; clock clk_i.
REQ-004 SHALL have flush_i (in, 1): kill the instruction held in ID.
REQ-005 SHALL have if_valid_i (in, 1), ifToId_i (in, 64: {pc[31:0], inst[31:0]}) and id_ready_o (out, 1): the IF->ID handshake.
REQ-006 SHALL have rf_raddr1_o and rf_raddr2_o (out, 5 each) and rf_rdata1_i and rf_rdata2_i (in, 32 each): the combinational regfile read ports.
REQ-007 SHALL have ex_valid_i (in, 1), ex_is_load_i (in, 1) and ex_rd_i (in, 5): the EX-stage occupant info used for load-use detection.
REQ-008 SHALL have id_valid_o (out, 1) and ex_ready_i (in, 1): the ID->EX handshake.
REQ-009 SHALL have pc_o (32), imm_o (32), rs1_data_o (32), rs2_data_o (32) and rd_o (5), all out.
REQ-010 SHALL have the following decode flags, all out: alu_op_o (4), wen_o, is_load_o, is_store_o, is_branch_o, is_jal_o, is_jalr_o, illegal_o (1 each).
REQ-011 SHALL have stall_cnt_o (out, 16): a count of load-use stall cycles.

Function
REQ-012 SHALL hold one stage register: valid_q, pc_q, inst_q.
REQ-013 SHALL compute stall = valid_q & ex_valid_i & ex_is_load_i & (ex_rd_i != 0) & ((uses_rs1 & ex_rd_i == rs1) | (uses_rs2 & ex_rd_i == rs2)).
- uses_rs1: R, I, S, B, JALR, LOAD formats.
- uses_rs2: R, S, B formats.
REQ-014 SHALL drive id_ready_o = !flush_i & (!valid_q | (ex_ready_i & !stall)).
REQ-015 SHALL drive id_valid_o = valid_q & !stall & !flush_i.
REQ-016 SHALL load the stage register on the clock edge when if_valid_i & id_ready_o: valid_q <= 1, {pc_q, inst_q} <= ifToId_i.
REQ-017 SHALL clear valid_q on the edge when id_valid_o & ex_ready_i and no new instruction is loaded in that cycle.
REQ-018 SHALL hold all stage-register contents unchanged while stall=1 or ex_ready_i=0.
REQ-019 SHALL handle flush_i=1 as follows:
- next edge: valid_q <= 0, inst_q <= NOP_INST;
- the input is ignored in that cycle;
- flush takes priority over simultaneous load, stall and ex_ready_i.
REQ-020 SHALL give zero-cycle decode latency: all outputs derive combinationally from pc_q and inst_q.
REQ-021 SHALL drive rf_raddr1_o = inst_q[19:15] and rf_raddr2_o = inst_q[24:20].
REQ-022 SHALL force rs1_data_o and rs2_data_o to 0 when the corresponding address is 0.
REQ-023 SHALL produce imm_o sign-extended from bit 31 per type:
- I: inst[31:20];
- S: {inst[31:25], inst[11:7]};
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0};
- U: {inst[31:12], 12'b0};
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0};
- R-type: 0.
REQ-024 SHALL decode all RV32I base opcodes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP).
REQ-025 SHALL decode any other opcode as illegal_o=1 with wen_o, is_load_o, is_store_o, is_branch_o, is_jal_o and is_jalr_o all 0.
REQ-026 SHALL drive wen_o=0 when rd_o==0 and when the instruction is a store or branch.
REQ-027 SHALL increment stall_cnt_o by 1 on each edge where stall=1, saturating at 16'hFFFF.
REQ-028 SHALL drive all decode outputs to 0 and illegal_o=0 when valid_q=0.

Reset
REQ-029 SHALL on rst_i assertion immediately force valid_q=0, pc_q=RESET_PC, inst_q=NOP_INST and stall_cnt_o=0.
REQ-030 SHALL drive id_valid_o=0 and id_ready_o=1 during reset.
REQ-031 SHALL discard any in-flight instruction when rst_i is asserted mid-operation.

Verification
REQ-032 SHALL cover: reset release, then one handshake with if_valid_i=1, ifToId_i={32'h8000_0000, 32'h0010_0093} -> next cycle id_valid_o=1, rd_o=1, imm_o=1, wen_o=1, alu_op_o=ADD.
REQ-033 SHALL cover: EX holds a load to x5 (ex_valid_i=1, ex_is_load_i=1, ex_rd_i=5) while ID holds add x6,x5,x7 -> id_valid_o=0 and id_ready_o=0 for 1 cycle, stall_cnt_o=1; clearing ex_valid_i releases the instruction unchanged.
REQ-034 SHALL cover: ex_ready_i=0 for 3 cycles with if_valid_i=1 -> the ID output is stable, id_ready_o=0, and no instruction is lost or duplicated after release.
REQ-035 SHALL cover: flush_i=1 concurrent with if_valid_i=1 and stall=1 -> next cycle valid_q=0 and id_valid_o=0, and the flushed input is not captured.
REQ-036 SHALL cover: inst 32'hFFFF_FFFF -> illegal_o=1, wen_o=0; B-type 32'hFE00_0EE3 -> imm_o=32'hFFFF_FFFC, is_branch_o=1.
REQ-037 SHALL cover: forcing 65540 stall cycles -> stall_cnt_o saturates at 16'hFFFF.
